// File: rtl/ll_pkg.sv
// Shared types for the linked-list walker: pointer type, null pointer
// and walker state encoding.
package ll_pkg;

  localparam int N_DEF = 16;
  localparam int W_DEF = $clog2(N_DEF);

  typedef logic [W_DEF-1:0] ptr_t;

  localparam ptr_t PTR_NULL = '0;

  typedef enum logic {
    IDLE,
    WALK
  } state_t;

endpackage

// File: rtl/ll_start_fifo.sv
// Start-pointer FIFO: head is read combinationally, pop advances the
// read pointer at the clock edge.
module ll_start_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign head  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/ll_walker.sv
// Linked-list walker: chases next pointers from queued list heads.
// Define LL_WALK_NO_GAP_EN to stream lists back-to-back with no idle cycle.
module ll_walker
  import ll_pkg::*;
#(
  parameter int N           = 16,
  parameter int START_DEPTH = 4,
  parameter int MAX_HOPS    = N,
  localparam int W          = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] start_ptr,
  input  logic         start_vld,
  output logic         start_rdy,
  input  logic         wr_en,
  input  logic [W-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] out_ptr,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic         out_last,
  output logic         out_err,
  output logic         busy
);

  localparam int HW = $clog2(MAX_HOPS + 1);
  localparam logic [HW-1:0] HC_LAST = HW'(MAX_HOPS - 1);
  localparam logic [W-1:0]  NUL     = W'(PTR_NULL);

  logic [W-1:0] tbl [N];

  logic [W-1:0] head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  state_t       state;
  state_t       nstate;
  logic [W-1:0] link_q;
  logic [HW-1:0] hc;

  logic          load;
  logic [W-1:0]  load_ptr;
  logic [HW-1:0] load_hc;
  logic [W-1:0]  rd;

  assign start_rdy = ~full & ~rst;
  assign push      = start_vld & start_rdy & (start_ptr != NUL);
  assign out_vld   = (state == WALK);
  assign busy      = out_vld | ~empty;

  ll_start_fifo #(
    .W     (W),
    .DEPTH (START_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (start_ptr),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // Same-cycle write to the node being loaded wins over the stored entry
  assign rd = (wr_en && wr_addr == load_ptr) ? wr_data : tbl[load_ptr];

  always_comb begin
    nstate   = state;
    load     = 1'b0;
    pop      = 1'b0;
    load_ptr = head;
    load_hc  = '0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          load   = 1'b1;
          nstate = WALK;
        end
      end
      WALK: begin
        if (out_rdy) begin
          if (!out_last) begin
            load     = 1'b1;
            load_ptr = link_q;
            load_hc  = hc + 1'b1;
          end else begin
`ifdef LL_WALK_NO_GAP_EN
            if (!empty) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              nstate = IDLE;
            end
`else
            nstate = IDLE;
`endif
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_ptr  <= '0;
      link_q   <= '0;
      hc       <= '0;
      out_last <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      state <= nstate;
      if (load) begin
        out_ptr  <= load_ptr;
        link_q   <= rd;
        hc       <= load_hc;
        out_last <= (rd == NUL) | (load_hc == HC_LAST);
        out_err  <= (rd != NUL) & (load_hc == HC_LAST);
      end
    end
  end

endmodule

// File: tb/tb_ll_walker.sv
// Scoreboard bench for ll_walker (N=16, START_DEPTH=4, MAX_HOPS=4).
// Honours LL_WALK_NO_GAP_EN for the inter-list gap expectation.
module tb_ll_walker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_ptr;
  logic       start_vld;
  logic       start_rdy;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] out_ptr;
  logic       out_vld;
  logic       out_rdy;
  logic       out_last;
  logic       out_err;
  logic       busy;

  typedef struct packed {
    logic [3:0] p;
    logic       l;
    logic       e;
  } exp_t;

  exp_t       sb [$];
  logic [3:0] hq [$];
  int checks = 0;
  int errors = 0;

`ifdef LL_WALK_NO_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  ll_walker #(
    .N           (16),
    .START_DEPTH (4),
    .MAX_HOPS    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_ptr (start_ptr),
    .start_vld (start_vld),
    .start_rdy (start_rdy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_ptr   (out_ptr),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_last  (out_last),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic offer(input logic [3:0] p);
    start_ptr = p; start_vld = 1'b1;
    tick();
    start_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({out_vld, out_ptr, out_last, out_err, busy, start_rdy} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state got vld=%b ptr=%0d last=%b err=%b busy=%b rdy=%b want all 0",
               out_vld, out_ptr, out_last, out_err, busy, start_rdy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (start_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy got %b want 1", start_rdy);
    end
  endtask

  task automatic test_basic;
    exp_t e;
    wr(1, 5); wr(5, 3); wr(3, 10);
    out_rdy = 1'b1;
    sb.push_back('{4'd1, 1'b0, 1'b0});
    sb.push_back('{4'd5, 1'b0, 1'b0});
    sb.push_back('{4'd3, 1'b0, 1'b0});
    sb.push_back('{4'd10, 1'b1, 1'b0});
    offer(1);
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency got vld=%b want 0 one edge after push", out_vld);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      checks++;
      if ({out_vld, out_ptr, out_last, out_err} !== {1'b1, e.p, e.l, e.e}) begin
        errors++;
        $display("FAIL basic_node%0d got vld=%b ptr=%0d last=%b err=%b want 1 %0d %b %b",
                 i, out_vld, out_ptr, out_last, out_err, e.p, e.l, e.e);
      end
      tick();
    end
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got vld=%b want 0", out_vld);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int t8 = -100;
    int t2 = 0;
    wr(7, 15); wr(15, 8); wr(2, 4);
    out_rdy = 1'b1;
    sb.push_back('{4'd7, 1'b0, 1'b0});
    sb.push_back('{4'd15, 1'b0, 1'b0});
    sb.push_back('{4'd8, 1'b1, 1'b0});
    sb.push_back('{4'd2, 1'b0, 1'b0});
    sb.push_back('{4'd4, 1'b1, 1'b0});
    offer(7);
    offer(2);
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (out_vld) begin
        e = sb.pop_front();
        checks++;
        if ({out_ptr, out_last, out_err} !== {e.p, e.l, e.e}) begin
          errors++;
          $display("FAIL b2b_node got ptr=%0d last=%b err=%b want %0d %b %b",
                   out_ptr, out_last, out_err, e.p, e.l, e.e);
        end
        if (out_ptr == 4'd8) t8 = c;
        if (out_ptr == 4'd2) t2 = c;
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_timeout got %0d nodes left want 0", sb.size());
      sb.delete();
    end
    checks++;
    if (t2 - t8 != GAP) begin
      errors++;
      $display("FAIL b2b_gap got %0d cycles from 8 to 2 want %0d", t2 - t8, GAP);
    end
  endtask

  task automatic test_backpressure;
    out_rdy = 1'b1;
    offer(1);
    tick();
    tick();
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_vld, out_ptr, out_last, out_err} !== {1'b1, 4'd5, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b ptr=%0d last=%b err=%b want 1 5 0 0",
                 i, out_vld, out_ptr, out_last, out_err);
      end
      tick();
    end
    out_rdy = 1'b1;
    tick();
    checks++;
    if ({out_vld, out_ptr, out_last} !== {1'b1, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL bp_resume got vld=%b ptr=%0d last=%b want 1 3 0",
               out_vld, out_ptr, out_last);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_cycle_guard;
    exp_t e;
    wr(9, 14); wr(14, 9);
    out_rdy = 1'b1;
    sb.push_back('{4'd9, 1'b0, 1'b0});
    sb.push_back('{4'd14, 1'b0, 1'b0});
    sb.push_back('{4'd9, 1'b0, 1'b0});
    sb.push_back('{4'd14, 1'b1, 1'b1});
    offer(9);
    tick();
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      checks++;
      if ({out_vld, out_ptr, out_last, out_err} !== {1'b1, e.p, e.l, e.e}) begin
        errors++;
        $display("FAIL guard_node%0d got vld=%b ptr=%0d last=%b err=%b want 1 %0d %b %b",
                 i, out_vld, out_ptr, out_last, out_err, e.p, e.l, e.e);
      end
      tick();
    end
    checks++;
    if ({out_vld, busy} !== 2'b00) begin
      errors++;
      $display("FAIL guard_idle got vld=%b busy=%b want 0 0", out_vld, busy);
    end
  endtask

  task automatic test_null_start;
    start_ptr = 4'd0; start_vld = 1'b1;
    checks++;
    if (start_rdy !== 1'b1) begin
      errors++;
      $display("FAIL null_rdy got %b want 1", start_rdy);
    end
    tick();
    start_vld = 1'b0;
    tick();
    checks++;
    if ({out_vld, busy} !== 2'b00) begin
      errors++;
      $display("FAIL null_quiet got vld=%b busy=%b want 0 0", out_vld, busy);
    end
  endtask

  task automatic test_forward;
    out_rdy = 1'b1;
    offer(5);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'd0;
    tick();
    wr_en = 1'b0;
    checks++;
    if ({out_vld, out_ptr, out_last, out_err} !== {1'b1, 4'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fwd_node got vld=%b ptr=%0d last=%b err=%b want 1 5 1 0",
               out_vld, out_ptr, out_last, out_err);
    end
    tick();
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL fwd_idle got vld=%b want 0", out_vld);
    end
  endtask

  task automatic test_fifo_full;
    logic [3:0] h [6] = '{4'd1, 4'd2, 4'd7, 4'd9, 4'd3, 4'd10};
    logic [3:0] x;
    int acc = 0;
    logic first = 1'b1;
    out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start_ptr = h[i]; start_vld = 1'b1;
      if (start_rdy) begin
        acc++;
        hq.push_back(h[i]);
      end
      tick();
    end
    start_vld = 1'b0;
    checks++;
    if (acc != 5) begin
      errors++;
      $display("FAIL full_accepted got %0d want 5", acc);
    end
    tick(); tick();
    checks++;
    if ({start_rdy, out_vld, out_ptr} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL full_stall got rdy=%b vld=%b ptr=%0d want 0 1 1",
               start_rdy, out_vld, out_ptr);
    end
    out_rdy = 1'b1;
    for (int c = 0; c < 100 && busy; c++) begin
      if (out_vld) begin
        if (first) begin
          x = hq.pop_front();
          checks++;
          if (out_ptr !== x) begin
            errors++;
            $display("FAIL full_head got %0d want %0d", out_ptr, x);
          end
        end
        if (hq.size() == 4) begin
          checks++;
          if (start_rdy !== 1'b0) begin
            errors++;
            $display("FAIL full_rdy_early got %b want 0", start_rdy);
          end
        end
        first = out_last;
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || hq.size() != 0) begin
      errors++;
      $display("FAIL full_drain got busy=%b left=%0d want 0 0", busy, hq.size());
      hq.delete();
    end
  endtask

  task automatic test_reset_mid;
    out_rdy = 1'b0;
    offer(7);
    tick();
    offer(2);
    rst = 1'b1;
    tick();
    checks++;
    if ({out_vld, out_ptr, busy, start_rdy} !== 7'b0) begin
      errors++;
      $display("FAIL rstmid_state got vld=%b ptr=%0d busy=%b rdy=%b want 0 0 0 0",
               out_vld, out_ptr, busy, start_rdy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flush got busy=%b want 0", busy);
    end
    out_rdy = 1'b1;
    offer(7);
    tick();
    checks++;
    if ({out_vld, out_ptr, out_last, out_err} !== {1'b1, 4'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_table got vld=%b ptr=%0d last=%b err=%b want 1 7 1 0",
               out_vld, out_ptr, out_last, out_err);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start_ptr = '0; start_vld = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_rdy = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_cycle_guard();
    test_null_start();
    test_forward();
    test_fifo_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
